// File: rtl/pc_dump_engine.sv
// Performance-counter dump engine: snapshots NUM_COUNTERS counters on pc_start and
// writes them to memory as a single AXI write burst (AW, then W beats, then B).
module pc_dump_engine #(
    parameter int PC_DATA_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int NUM_COUNTERS   = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    pc_start,
    input  logic [AXI_ADDR_WIDTH-1:0]               pc_base_addr,
    input  logic [NUM_COUNTERS*PC_DATA_WIDTH-1:0]   pc_counters,
    output logic                                    pc_busy,
    output logic                                    pc_done,
    output logic                                    pc_err,
    output logic [AXI_ADDR_WIDTH-1:0]               axi_st_addr,
    output logic                                    axi_st_addr_v,
    input  logic                                    axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]               axi_st_size,
    output logic [AXI_DATA_WIDTH-1:0]               axi_st_data,
    output logic                                    axi_st_data_v,
    output logic                                    axi_st_last,
    input  logic                                    axi_wready,
    input  logic                                    axi_bvalid,
    input  logic [1:0]                              axi_bresp,
    output logic                                    axi_bready,
    output logic [2:0]                              dbg_state
);

    localparam int K          = AXI_DATA_WIDTH / PC_DATA_WIDTH;
    localparam int NUM_BEATS  = (NUM_COUNTERS + K - 1) / K;
    localparam int BYTES      = NUM_BEATS * AXI_DATA_WIDTH / 8;
    localparam int SNAP_W     = NUM_BEATS * AXI_DATA_WIDTH;
    localparam int LSB_W      = $clog2(AXI_DATA_WIDTH / 8);
    localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK   = AXI_ADDR_WIDTH'((1 << LSB_W) - 1);
    localparam logic [BEAT_W-1:0]         LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);
    localparam logic [TIMER_W-1:0]        TIMER_LAST = TIMER_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AW_REQ = 3'd1,
        S_W_DATA = 3'd2,
        S_B_WAIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [AXI_DATA_WIDTH-1:0]    snap [NUM_BEATS];
    logic [SNAP_W-1:0]            snap_in;
    logic [AXI_ADDR_WIDTH-1:0]    addr;
    logic [BEAT_W-1:0]            beat;
    logic [TIMER_W-1:0]           timer;
    logic                         err;

    logic                         capture;
    logic                         beat_clr;
    logic                         beat_inc;
    logic                         err_load;
    logic                         err_val;

    // Slots past NUM_COUNTERS in the final beat are zero-filled by the widening cast.
    assign snap_in = SNAP_W'(pc_counters);

    // Handshake rule on AW, W and B: a transfer happens on a clock edge where
    // valid and ready are both high; valid, address, data and last stay constant
    // until that edge. B is accepted whenever bready is high in B_WAIT.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        beat_clr   = 1'b0;
        beat_inc   = 1'b0;
        err_load   = 1'b0;
        err_val    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pc_start) begin
                    capture    = 1'b1;
                    state_next = S_AW_REQ;
                end
            end
            S_AW_REQ: begin
                if (axi_awready) begin
                    beat_clr   = 1'b1;
                    state_next = S_W_DATA;
                end
            end
            S_W_DATA: begin
                if (axi_wready) begin
                    beat_inc = 1'b1;
                    if (beat == LAST_BEAT) state_next = S_B_WAIT;
                end
            end
            S_B_WAIT: begin
                // A response arriving on the timeout cycle takes priority.
                if (axi_bvalid) begin
                    err_load   = 1'b1;
                    err_val    = |axi_bresp;
                    state_next = S_DONE;
                end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
                    err_load   = 1'b1;
                    err_val    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            addr  <= '0;
            beat  <= '0;
            timer <= '0;
            err   <= 1'b0;
            for (int b = 0; b < NUM_BEATS; b++) snap[b] <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr <= pc_base_addr & ~LOW_MASK;
                err  <= 1'b0;
                for (int b = 0; b < NUM_BEATS; b++) snap[b] <= snap_in[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
            if (beat_clr)      beat <= '0;
            else if (beat_inc) beat <= beat + 1'b1;
            timer <= (state == S_B_WAIT) ? timer + 1'b1 : '0;
            if (err_load) err <= err_val;
        end
    end

    assign pc_busy       = (state != S_IDLE);
    assign pc_done       = (state == S_DONE);
    assign pc_err        = (state == S_DONE) && err;
    assign axi_st_addr   = addr;
    assign axi_st_addr_v = (state == S_AW_REQ);
    assign axi_st_size   = AXI_DATA_WIDTH'(BYTES);
    assign axi_st_data   = (state == S_W_DATA) ? snap[beat] : '0;
    assign axi_st_data_v = (state == S_W_DATA);
    assign axi_st_last   = (state == S_W_DATA) && (beat == LAST_BEAT);
    assign axi_bready    = (state == S_B_WAIT);
    assign dbg_state     = state;

endmodule

// File: tb/tb_pc_dump_engine.sv
// Bench for pc_dump_engine: a default instance (24 counters, 4096-cycle timeout) and a
// small instance (5 counters, 16-cycle timeout) share stimulus and are checked against a model.
module tb_pc_dump_engine;

    localparam int PCW = 64;
    localparam int AXW = 128;
    localparam int ADW = 64;
    localparam int NM  = 24;
    localparam int NS  = 5;
    localparam int TM  = 4096;
    localparam int TS  = 16;
    localparam int KB  = AXW / PCW;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               pc_start;
    logic [ADW-1:0]     pc_base_addr;
    logic [NM*PCW-1:0]  pc_counters;
    logic               axi_awready, axi_wready, axi_bvalid;
    logic [1:0]         axi_bresp;
    logic               d_awready, d_wready, d_bvalid;
    logic               r_awready = 1'b1, r_wready = 1'b1, r_bvalid = 1'b1;
    bit                 rand_mode = 1'b0;

    assign axi_awready = rand_mode ? r_awready : d_awready;
    assign axi_wready  = rand_mode ? r_wready  : d_wready;
    assign axi_bvalid  = rand_mode ? r_bvalid  : d_bvalid;

    logic            m_busy, m_done, m_err, m_addr_v, m_data_v, m_last, m_bready;
    logic [ADW-1:0]  m_addr;
    logic [AXW-1:0]  m_size, m_data;
    logic [2:0]      m_state;
    logic            s_busy, s_done, s_err, s_addr_v, s_data_v, s_last, s_bready;
    logic [ADW-1:0]  s_addr;
    logic [AXW-1:0]  s_size, s_data;
    logic [2:0]      s_state;

    pc_dump_engine #(.PC_DATA_WIDTH(PCW), .AXI_DATA_WIDTH(AXW), .AXI_ADDR_WIDTH(ADW),
                     .NUM_COUNTERS(NM), .TIMEOUT_CYCLES(TM)) dut_m (
        .clk(clk), .reset_n(reset_n), .pc_start(pc_start), .pc_base_addr(pc_base_addr),
        .pc_counters(pc_counters), .pc_busy(m_busy), .pc_done(m_done), .pc_err(m_err),
        .axi_st_addr(m_addr), .axi_st_addr_v(m_addr_v), .axi_awready(axi_awready),
        .axi_st_size(m_size), .axi_st_data(m_data), .axi_st_data_v(m_data_v),
        .axi_st_last(m_last), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
        .axi_bresp(axi_bresp), .axi_bready(m_bready), .dbg_state(m_state));

    pc_dump_engine #(.PC_DATA_WIDTH(PCW), .AXI_DATA_WIDTH(AXW), .AXI_ADDR_WIDTH(ADW),
                     .NUM_COUNTERS(NS), .TIMEOUT_CYCLES(TS)) dut_s (
        .clk(clk), .reset_n(reset_n), .pc_start(pc_start), .pc_base_addr(pc_base_addr),
        .pc_counters(pc_counters[NS*PCW-1:0]), .pc_busy(s_busy), .pc_done(s_done), .pc_err(s_err),
        .axi_st_addr(s_addr), .axi_st_addr_v(s_addr_v), .axi_awready(axi_awready),
        .axi_st_size(s_size), .axi_st_data(s_data), .axi_st_data_v(s_data_v),
        .axi_st_last(s_last), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
        .axi_bresp(axi_bresp), .axi_bready(s_bready), .dbg_state(s_state));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        r_awready = ($urandom_range(0, 1) == 1);
        r_wready  = ($urandom_range(0, 3) != 0);
        r_bvalid  = ($urandom_range(0, 1) == 1);
    end

    // monitors: sample on the falling edge, between driver updates
    logic [AXW-1:0] m_w_q[$], s_w_q[$];
    bit             m_last_q[$], s_last_q[$];
    logic [ADW-1:0] m_aw_q[$], s_aw_q[$];
    int             m_done_cnt = 0, s_done_cnt = 0, m_done_cyc = 0, s_done_cyc = 0, m_bw = 0, s_bw = 0;
    logic           m_done_err, s_done_err, m_got_b, s_got_b;
    logic [1:0]     m_b_resp, s_b_resp;
    logic           m_stall = 1'b0, s_stall = 1'b0;
    logic [AXW-1:0] m_hold, s_hold;

    always @(negedge clk) begin
        if (m_stall && reset_n) begin
            chk("m_hold_valid", m_data_v, 1'b1);
            chk("m_hold_data", m_data, m_hold);
        end
        if (s_stall && reset_n) begin
            chk("s_hold_valid", s_data_v, 1'b1);
            chk("s_hold_data", s_data, s_hold);
        end
        m_stall = m_data_v && !axi_wready;
        m_hold  = m_data;
        s_stall = s_data_v && !axi_wready;
        s_hold  = s_data;
        if (m_addr_v && axi_awready) m_aw_q.push_back(m_addr);
        if (s_addr_v && axi_awready) s_aw_q.push_back(s_addr);
        if (m_data_v && axi_wready) begin m_w_q.push_back(m_data); m_last_q.push_back(m_last); end
        if (s_data_v && axi_wready) begin s_w_q.push_back(s_data); s_last_q.push_back(s_last); end
        if (m_bready) begin m_bw++; if (axi_bvalid && !m_got_b) begin m_got_b = 1'b1; m_b_resp = axi_bresp; end end
        if (s_bready) begin s_bw++; if (axi_bvalid && !s_got_b) begin s_got_b = 1'b1; s_b_resp = axi_bresp; end end
        if (m_done) begin m_done_cnt++; m_done_cyc = cyc; m_done_err = m_err; end
        if (s_done) begin s_done_cnt++; s_done_cyc = cyc; s_done_err = s_err; end
    end

    // reference model: counters laid out K per beat, LSB first, zero past the end
    logic [PCW-1:0] cnt_model[NM];
    logic [AXW-1:0] exp_m_q[$], exp_s_q[$];
    logic [ADW-1:0] exp_addr;

    function automatic int beats_for(int n);
        return (n + KB - 1) / KB;
    endfunction

    function automatic logic [AXW-1:0] model_beat(int b, int n);
        logic [AXW-1:0] r;
        r = '0;
        for (int s = 0; s < KB; s++)
            if (b * KB + s < n) r[s*PCW +: PCW] = cnt_model[b * KB + s];
        return r;
    endfunction

    task automatic load_model();
        for (int i = 0; i < NM; i++) cnt_model[i] = pc_counters[i*PCW +: PCW];
        exp_m_q.delete();
        exp_s_q.delete();
        for (int b = 0; b < beats_for(NM); b++) exp_m_q.push_back(model_beat(b, NM));
        for (int b = 0; b < beats_for(NS); b++) exp_s_q.push_back(model_beat(b, NS));
    endtask

    task automatic scramble_counters();
        for (int i = 0; i < NM; i++) pc_counters[i*PCW +: PCW] = {$urandom, $urandom};
    endtask

    // driver tasks
    task automatic start_dump(input logic [ADW-1:0] base);
        @(posedge clk); #1;
        m_w_q.delete(); s_w_q.delete(); m_last_q.delete(); s_last_q.delete();
        m_aw_q.delete(); s_aw_q.delete();
        m_bw = 0; s_bw = 0; m_got_b = 1'b0; s_got_b = 1'b0;
        pc_base_addr = base;
        pc_start     = 1'b1;
        start_cyc    = cyc;
        load_model();
        exp_addr = base & ~64'hF;
        @(posedge clk); #1;
        pc_start = 1'b0;
        scramble_counters();
    endtask

    task automatic wait_done(input int m_tgt, input int s_tgt, input int budget);
        int n = 0;
        while ((m_done_cnt < m_tgt || s_done_cnt < s_tgt) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("m_done_seen", m_done_cnt, m_tgt);
        chk("s_done_seen", s_done_cnt, s_tgt);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_beats(input int nb, input int budget);
        int n = 0;
        while (m_w_q.size() < nb && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("m_beats_reached", m_w_q.size(), nb);
    endtask

    task automatic ready_all_high();
        rand_mode = 1'b0;
        @(posedge clk); #2;
        d_awready = 1'b1; d_wready = 1'b1; d_bvalid = 1'b1;
    endtask

    task automatic chk_idle_outputs();
        chk("m_rst_busy", m_busy, 1'b0);    chk("s_rst_busy", s_busy, 1'b0);
        chk("m_rst_done", m_done, 1'b0);    chk("s_rst_done", s_done, 1'b0);
        chk("m_rst_err", m_err, 1'b0);      chk("s_rst_err", s_err, 1'b0);
        chk("m_rst_addr", m_addr, 0);       chk("s_rst_addr", s_addr, 0);
        chk("m_rst_addr_v", m_addr_v, 1'b0); chk("s_rst_addr_v", s_addr_v, 1'b0);
        chk("m_rst_data", m_data, 0);       chk("s_rst_data", s_data, 0);
        chk("m_rst_data_v", m_data_v, 1'b0); chk("s_rst_data_v", s_data_v, 1'b0);
        chk("m_rst_last", m_last, 1'b0);    chk("s_rst_last", s_last, 1'b0);
        chk("m_rst_bready", m_bready, 1'b0); chk("s_rst_bready", s_bready, 1'b0);
        chk("m_rst_size", m_size, beats_for(NM) * AXW / 8);
        chk("s_rst_size", s_size, beats_for(NS) * AXW / 8);
    endtask

    // scoreboard: drain captured beats against the expected queues
    task automatic check_run(input int lat_m, input int lat_s);
        logic [AXW-1:0] e;
        int i;
        chk("m_aw_count", m_aw_q.size(), 1);
        if (m_aw_q.size() > 0) chk("m_aw_addr", m_aw_q[0], exp_addr);
        chk("s_aw_count", s_aw_q.size(), 1);
        if (s_aw_q.size() > 0) chk("s_aw_addr", s_aw_q[0], exp_addr);
        chk("m_size", m_size, beats_for(NM) * AXW / 8);
        chk("s_size", s_size, beats_for(NS) * AXW / 8);
        chk("m_beat_count", m_w_q.size(), exp_m_q.size());
        chk("s_beat_count", s_w_q.size(), exp_s_q.size());
        i = 0;
        while (exp_m_q.size() > 0) begin
            e = exp_m_q.pop_front();
            if (i < m_w_q.size()) begin
                chk("m_beat_data", m_w_q[i], e);
                chk("m_beat_last", m_last_q[i], exp_m_q.size() == 0);
            end
            i++;
        end
        i = 0;
        while (exp_s_q.size() > 0) begin
            e = exp_s_q.pop_front();
            if (i < s_w_q.size()) begin
                chk("s_beat_data", s_w_q[i], e);
                chk("s_beat_last", s_last_q[i], exp_s_q.size() == 0);
            end
            i++;
        end
        chk("m_err", m_done_err, m_got_b ? (m_b_resp != 2'b00) : 1'b1);
        chk("s_err", s_done_err, s_got_b ? (s_b_resp != 2'b00) : 1'b1);
        if (!m_got_b) chk("m_timeout_len", m_bw, TM);
        if (!s_got_b) chk("s_timeout_len", s_bw, TS);
        if (lat_m != 0) chk("m_latency", m_done_cyc - start_cyc + 1, lat_m);
        if (lat_s != 0) chk("s_latency", s_done_cyc - start_cyc + 1, lat_s);
        chk("m_busy_after", m_busy, 1'b0);
        chk("s_busy_after", s_busy, 1'b0);
    endtask

    initial begin
        int mt, st;
        reset_n = 1'b0; pc_start = 1'b0; pc_base_addr = '0; pc_counters = '0;
        d_awready = 1'b1; d_wready = 1'b1; d_bvalid = 1'b1; axi_bresp = 2'b00;
        #1;
        chk_idle_outputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: counter i = i+1, base 0x1000, everything ready
        for (int i = 0; i < NM; i++) pc_counters[i*PCW +: PCW] = 64'(i + 1);
        start_dump(64'h1000);
        wait_done(1, 1, 200);
        if (m_aw_q.size() > 0) chk("t1_aw_addr", m_aw_q[0], 64'h1000);
        if (m_w_q.size() == 12) begin
            chk("t1_beat0", m_w_q[0], {64'd2, 64'd1});
            chk("t1_beat11", m_w_q[11], {64'd24, 64'd23});
        end
        if (s_w_q.size() == 3) chk("t1_small_beat2", s_w_q[2], {64'd0, 64'd5});
        chk("t1_m_err", m_done_err, 1'b0);
        check_run(16, 7);

        // 2: restart ignored while busy, beat 3 stalled for 5 cycles
        scramble_counters();
        start_dump({$urandom, $urandom});
        wait_beats(1, 50);
        pc_base_addr = {$urandom, $urandom};
        pc_start = 1'b1;
        @(posedge clk); #1;
        pc_start = 1'b0;
        wait_beats(3, 50);
        d_wready = 1'b0;
        repeat (5) @(posedge clk);
        #1 d_wready = 1'b1;
        wait_done(2, 2, 200);
        check_run(21, 7);
        repeat (20) @(negedge clk);
        chk("t2_no_second_m", m_done_cnt, 2);
        chk("t2_no_second_s", s_done_cnt, 2);
        chk("t2_aw_once_m", m_aw_q.size(), 1);
        chk("t2_aw_once_s", s_aw_q.size(), 1);

        // 3: error response under random handshakes
        axi_bresp = 2'b10;
        rand_mode = 1'b1;
        mt = m_done_cnt + 1; st = s_done_cnt + 1;
        start_dump({$urandom, $urandom});
        wait_done(mt, st, 600);
        ready_all_high();
        chk("t3_m_err", m_done_err, 1'b1);
        chk("t3_s_err", s_done_err, 1'b1);
        check_run(0, 0);

        // 4: no B response, both instances time out
        axi_bresp = 2'b00;
        d_bvalid  = 1'b0;
        mt = m_done_cnt + 1; st = s_done_cnt + 1;
        start_dump({$urandom, $urandom});
        wait_done(mt, st, 5000);
        chk("t4_m_err", m_done_err, 1'b1);
        chk("t4_s_err", s_done_err, 1'b1);
        chk("t4_s_bwait", s_bw, TS);
        chk("t4_m_bwait", m_bw, TM);
        check_run(16 + TM - 1, 7 + TS - 1);
        d_bvalid = 1'b1;

        // 5: reset during beat 5 abandons the burst
        mt = m_done_cnt;
        start_dump({$urandom, $urandom});
        wait_beats(5, 50);
        #1 reset_n = 1'b0;
        #1;
        chk_idle_outputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_no_done_m", m_done_cnt, mt);
        chk("t5_idle_m", m_busy, 1'b0);
        mt = m_done_cnt + 1; st = s_done_cnt + 1;
        start_dump({$urandom, $urandom});
        wait_done(mt, st, 200);
        check_run(16, 7);

        // 6: random dumps with random responses
        for (int r = 0; r < 4; r++) begin
            axi_bresp = 2'($urandom_range(0, 3));
            rand_mode = 1'b1;
            mt = m_done_cnt + 1; st = s_done_cnt + 1;
            start_dump({$urandom, $urandom});
            wait_done(mt, st, 600);
            ready_all_high();
            check_run(0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_dump_engine.md
Name: pc_dump_engine

Overview:
Parametrised successor to the performance-counter dump logic. On a start request it snapshots NUM_COUNTERS performance counters and packs them into AXI_DATA_WIDTH beats. It then writes them to DDR as a single burst through the shared AXI store port with full AW/W/B handshaking, wready backpressure and bresp error reporting. It sits beside the controller and reports completion on pc_done.

Parameters:
PC_DATA_WIDTH, 64, width of one counter.
AXI_DATA_WIDTH, 128, AXI write data width; must be an integer multiple of PC_DATA_WIDTH.
AXI_ADDR_WIDTH, 64, AXI address width.
NUM_COUNTERS, 24, number of counters dumped; must be at least 1.
TIMEOUT_CYCLES, 4096, maximum number of B_WAIT cycles before an error is flagged; 0 disables the timeout.
Derived values:
- K = AXI_DATA_WIDTH/PC_DATA_WIDTH (counters per beat).
- NUM_BEATS = ceil(NUM_COUNTERS/K).
- BYTES = NUM_BEATS*AXI_DATA_WIDTH/8.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous, active-low reset.
pc_start  in  1  start pulse; sampled only in IDLE.
pc_base_addr  in  AXI_ADDR_WIDTH  DDR destination address; sampled with pc_start.
pc_counters  in  NUM_COUNTERS*PC_DATA_WIDTH  flat counter vector; counter i occupies bits [i*PC_DATA_WIDTH +: PC_DATA_WIDTH].
pc_busy  out  1  high whenever the state is not IDLE.
pc_done  out  1  one-cycle completion pulse.
pc_err  out  1  valid with pc_done; 1 = bresp error or timeout.
axi_st_addr  out  AXI_ADDR_WIDTH  burst address.
axi_st_addr_v  out  1  AW valid.
axi_awready  in  1  AW ready.
axi_st_size  out  AXI_DATA_WIDTH  burst size in bytes, constant BYTES.
axi_st_data  out  AXI_DATA_WIDTH  W data.
axi_st_data_v  out  1  W valid.
axi_st_last  out  1  W last.
axi_wready  in  1  W ready.
axi_bvalid  in  1  B valid.
axi_bresp  in  2  B response.
axi_bready  out  1  B ready.

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE. All outputs are 0 except axi_st_size, which is the constant BYTES. Snapshot, beat counter and timer are cleared. Reset asserted mid-burst abandons the transfer; no pc_done is produced.
- States: IDLE, AW_REQ, W_DATA, B_WAIT, DONE.
- IDLE:
  - pc_start=1 captures pc_counters into the snapshot register.
  - It also captures pc_base_addr with the low log2(AXI_DATA_WIDTH/8) bits cleared.
  - Next state is AW_REQ, so axi_st_addr_v rises the cycle after pc_start.
- AW_REQ: axi_st_addr_v=1 with axi_st_addr held stable. When axi_awready=1, go to W_DATA and set beat=0.
- W_DATA:
  - axi_st_data_v=1; axi_st_data = snapshot beat `beat`.
  - Slot s (LSB first) of beat b holds counter b*K+s. Slots with index >= NUM_COUNTERS are zero.
  - axi_st_last=1 when beat=NUM_BEATS-1.
  - Data, valid and last stay stable while axi_wready=0.
  - On axi_wready=1, increment beat. On the last beat go to B_WAIT.
  - Back-to-back beats: one beat per cycle while axi_wready stays high.
- B_WAIT:
  - axi_bready=1 and the timer increments every cycle.
  - On axi_bvalid=1, latch err = (axi_bresp!=0) and go to DONE.
  - If TIMEOUT_CYCLES!=0 and the timer reaches TIMEOUT_CYCLES, set err=1 and go to DONE.
  - If bvalid arrives in the same cycle as the timeout, bvalid wins and err = (bresp!=0).
- DONE: pc_done=1 and pc_err=err for exactly one cycle, then IDLE.
- Start and snapshot rules:
  - pc_start while pc_busy=1 is ignored; it is not queued.
  - The snapshot is immune to pc_counters changes after the capture cycle.
- Minimum latency from pc_start to pc_done, with awready, wready and bvalid all held high: 1 + 1 + NUM_BEATS + 1 + 1 cycles.
- All outputs are registered or decoded from state plus registers; there is no combinational path from any AXI input to any output.

Test Plan:
- Defaults, all ready signals tied high, counter i = i+1, base=0x1000 → AW addr 0x1000, size=192, 12 beats. Beat 0 = {64'd2,64'd1}, beat 11 = {64'd24,64'd23}. last on beat 11 only. pc_done 16 cycles after pc_start with pc_err=0.
- Hold axi_wready low for 5 cycles on beat 3 → beat 3 data and valid held stable. Total 12 handshakes, no beat skipped or duplicated. pc_done delayed by 5 cycles.
- NUM_COUNTERS=5, K=2 → 3 beats; beat 2 = {64'd0,counter4}; size=48.
- bresp=2'b10 → pc_done with pc_err=1. TIMEOUT_CYCLES=16 with bvalid never asserted → pc_done with pc_err=1 after exactly 16 B_WAIT cycles.
- pc_start pulsed again during W_DATA, and pc_counters changed after capture → no second burst; dumped data equals the values present at capture.
- reset_n dropped during beat 5 → all outputs 0 immediately. After release, a fresh pc_start performs a complete 12-beat dump.
